// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: picks the next-PC source for pc_module each cycle
// (hold, increment, branch, call, return, interrupt entry), keeps a tagged
// return-address stack and inserts flush bubbles after every redirect.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal issue; requests are arbitrated by priority
//   ST_FLUSH | post-redirect bubble; PC held, fetch invalid, requests ignored
module pc_flow_ctrl #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VEC    = 8'h00,
    parameter logic [WIDTH-1:0] IRQ_VEC      = 8'hF0,
    parameter int               STACK_DEPTH  = 4,
    parameter int               FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             stall,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic             irq,
    output logic             sel,
    output logic [WIDTH-1:0] jump_to,
    output logic             fetch_valid,
    output logic             irq_ack,
    output logic             in_isr,
    output logic             stack_full,
    output logic             stack_err
);

    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam int IW  = SPW - 1;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             irq_pend_q, irq_pend_d;
    logic             in_isr_q, in_isr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stk_addr_q [STACK_DEPTH];
    logic             stk_tag_q  [STACK_DEPTH];

    logic             push_en;
    logic [WIDTH-1:0] push_addr;
    logic             push_tag;
    logic             redirect;
    logic             stk_empty;
    logic             irq_take;
    logic [SPW-1:0]   sp_m1;
    logic [WIDTH-1:0] top_addr;
    logic             top_tag;

    assign stack_full = (sp_q == SPW'(STACK_DEPTH));
    assign stk_empty  = (sp_q == '0);
    assign sp_m1      = sp_q - {{(SPW-1){1'b0}}, 1'b1};
    assign top_addr   = stk_addr_q[sp_m1[IW-1:0]];
    assign top_tag    = stk_tag_q[sp_m1[IW-1:0]];
    assign irq_take   = (irq_pend_q | irq) & ~in_isr_q & ~stack_full;
    assign in_isr     = in_isr_q;
    assign stack_err  = err_q;

    // Arbitration, next-state and PC-select outputs for the current cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sp_d        = sp_q;
        irq_pend_d  = irq_pend_q | irq;
        in_isr_d    = in_isr_q;
        err_d       = err_q;
        push_en     = 1'b0;
        push_addr   = pc_in;
        push_tag    = 1'b0;
        redirect    = 1'b0;
        sel         = 1'b1;
        jump_to     = pc_in;
        fetch_valid = 1'b0;
        irq_ack     = 1'b0;

        if (rst) begin
            jump_to = RESET_VEC;
        end else if (state_q == ST_FLUSH) begin
            if (cnt_q == 3'd0) state_d = ST_RUN;
            else               cnt_d   = cnt_q - 3'd1;
        end else if (!stall) begin
            fetch_valid = 1'b1;
            if (irq_take) begin
                push_en    = 1'b1;
                push_tag   = 1'b1;
                sp_d       = sp_q + {{(SPW-1){1'b0}}, 1'b1};
                jump_to    = IRQ_VEC;
                irq_ack    = 1'b1;
                in_isr_d   = 1'b1;
                irq_pend_d = 1'b0;
                redirect   = 1'b1;
            end else if (ret_req) begin
                if (!stk_empty) begin
                    sp_d     = sp_m1;
                    jump_to  = top_addr;
                    redirect = 1'b1;
                    if (top_tag) in_isr_d = 1'b0;
                end else begin
                    sel   = 1'b0;
                    err_d = 1'b1;
                end
            end else if (call_req) begin
                jump_to  = br_target;
                redirect = 1'b1;
                if (!stack_full) begin
                    push_en   = 1'b1;
                    push_addr = pc_in + {{(WIDTH-1){1'b0}}, 1'b1};
                    sp_d      = sp_q + {{(SPW-1){1'b0}}, 1'b1};
                end else begin
                    err_d = 1'b1;
                end
            end else if (br_req) begin
                jump_to  = br_target;
                redirect = 1'b1;
            end else begin
                sel = 1'b0;
            end

            if (redirect && (FLUSH_CYCLES != 0)) begin
                state_d = ST_FLUSH;
                cnt_d   = 3'(FLUSH_CYCLES - 1);
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 3'd0;
            sp_q       <= '0;
            irq_pend_q <= 1'b0;
            in_isr_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sp_q       <= sp_d;
            irq_pend_q <= irq_pend_d;
            in_isr_q   <= in_isr_d;
            err_q      <= err_d;
        end
    end

    // Stack storage; contents above the pointer are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stk_addr_q[sp_q[IW-1:0]] <= push_addr;
            stk_tag_q[sp_q[IW-1:0]]  <= push_tag;
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: a PC register stands in for pc_module, and a
// queue-based reference model predicts every output and the PC sequence.
module tb_pc_flow_ctrl;

    localparam logic [7:0] RV = 8'h00;
    localparam logic [7:0] IV = 8'hF0;
    localparam int         D  = 4;
    localparam int         FC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, stall = 1'b0, br_req = 1'b0, call_req = 1'b0;
    logic       ret_req = 1'b0, irq = 1'b0;
    logic [7:0] br_target = 8'h00;
    logic       sel, fetch_valid, irq_ack, in_isr, stack_full, stack_err;
    logic [7:0] jump_to;
    logic [7:0] pc_q = 8'h37;

    // Stand-in for pc_module.
    always @(posedge clk) pc_q <= sel ? jump_to : pc_q + 8'd1;

    pc_flow_ctrl #(
        .WIDTH(8), .RESET_VEC(RV), .IRQ_VEC(IV),
        .STACK_DEPTH(D), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst(rst), .pc_in(pc_q), .stall(stall),
        .br_req(br_req), .br_target(br_target), .call_req(call_req),
        .ret_req(ret_req), .irq(irq), .sel(sel), .jump_to(jump_to),
        .fetch_valid(fetch_valid), .irq_ack(irq_ack), .in_isr(in_isr),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_pc = 8'h37;
    int         m_flush = 0;
    logic [7:0] m_sa [$];
    logic       m_st [$];
    logic       m_pend = 1'b0, m_isr = 1'b0, m_err = 1'b0;
    logic       m_known = 1'b0;
    logic       s_ack, s_fv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; stall = 1'b0; br_req = 1'b0; call_req = 1'b0;
        ret_req = 1'b0; irq = 1'b0;
    endtask

    // One cycle: called at negedge with inputs set; checks, then advances the model.
    task automatic step();
        logic       e_sel, e_fv, e_ack, take, jump;
        logic [7:0] n_pc;
        #2;
        if (m_known) begin
            chk("pc", pc_q, m_pc);
            chk("in_isr", in_isr, m_isr);
            chk("stack_full", stack_full, (m_sa.size() == D));
            chk("stack_err", stack_err, m_err);
        end
        e_sel = 1'b1; e_fv = 1'b0; e_ack = 1'b0; jump = 1'b0; n_pc = m_pc;
        if (rst) begin
            n_pc = RV;
            m_sa.delete(); m_st.delete();
            m_pend = 1'b0; m_isr = 1'b0; m_err = 1'b0; m_flush = 0;
            m_known = 1'b1;
        end else if (m_flush > 0) begin
            m_flush--;
            m_pend |= irq;
        end else if (stall) begin
            m_pend |= irq;
        end else begin
            e_fv = 1'b1;
            take = (m_pend || irq) && !m_isr && (m_sa.size() < D);
            if (take) begin
                m_sa.push_back(m_pc); m_st.push_back(1'b1);
                n_pc = IV; e_ack = 1'b1; m_isr = 1'b1; m_pend = 1'b0; jump = 1'b1;
            end else begin
                m_pend |= irq;
                if (ret_req) begin
                    if (m_sa.size() > 0) begin
                        n_pc = m_sa.pop_back();
                        if (m_st.pop_back()) m_isr = 1'b0;
                        jump = 1'b1;
                    end else begin
                        e_sel = 1'b0; n_pc = m_pc + 8'd1; m_err = 1'b1;
                    end
                end else if (call_req) begin
                    if (m_sa.size() < D) begin
                        m_sa.push_back(m_pc + 8'd1); m_st.push_back(1'b0);
                    end else begin
                        m_err = 1'b1;
                    end
                    n_pc = br_target; jump = 1'b1;
                end else if (br_req) begin
                    n_pc = br_target; jump = 1'b1;
                end else begin
                    e_sel = 1'b0; n_pc = m_pc + 8'd1;
                end
            end
            if (jump) m_flush = FC;
        end
        chk("sel", sel, e_sel);
        if (e_sel) chk("jump_to", jump_to, n_pc);
        chk("fetch_valid", fetch_valid, e_fv);
        chk("irq_ack", irq_ack, e_ack);
        s_ack = irq_ack;
        s_fv  = fetch_valid;
        @(posedge clk);
        m_pc = n_pc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_pc", pc_q, RV);
    endtask

    task automatic idle_until(input logic [7:0] a);
        int k = 0;
        clr_in();
        while (pc_q !== a && k < 600) begin
            step(); k++;
        end
        chk("reach_pc", pc_q, a);
    endtask

    task automatic do_call(input logic [7:0] t);
        call_req = 1'b1; br_target = t; step(); clr_in(); step();
    endtask

    task automatic do_ret();
        ret_req = 1'b1; step(); clr_in(); step();
    endtask

    logic [7:0] ret_exp [5];
    logic       ack_seen;

    initial begin
        @(negedge clk);

        // Reset from 8'h37, free-run with wrap
        do_reset();
        repeat (256) step();
        chk("wrap_pc", pc_q, 8'h00);

        // Branch with one bubble
        do_reset();
        idle_until(8'h05);
        br_req = 1'b1; br_target = 8'h40; step(); clr_in();
        chk("br_pc", pc_q, 8'h40);
        step();
        chk("br_hold_pc", pc_q, 8'h40);
        chk("br_bubble_fv", s_fv, 1'b0);
        step();
        chk("br_next_pc", pc_q, 8'h41);

        // Call / return
        do_reset();
        idle_until(8'h10);
        call_req = 1'b1; br_target = 8'h80; step(); clr_in();
        idle_until(8'h82);
        ret_req = 1'b1; step(); clr_in();
        chk("ret_pc", pc_q, 8'h11);
        step();
        chk("ret_err", stack_err, 1'b0);
        chk("ret_full", stack_full, 1'b0);

        // IRQ during stall, nested call inside ISR
        do_reset();
        idle_until(8'h20);
        stall = 1'b1; irq = 1'b1; step(); irq = 1'b0;
        step(); step();
        stall = 1'b0; step();
        chk("irq_ack_pulse", s_ack, 1'b1);
        chk("irq_pc", pc_q, IV);
        chk("irq_in_isr", in_isr, 1'b1);
        step(); step();
        do_call(8'h90);
        do_ret();
        chk("isr_nested_in_isr", in_isr, 1'b1);
        ret_req = 1'b1; step(); clr_in();
        chk("isr_ret_pc", pc_q, 8'h20);
        chk("isr_ret_in_isr", in_isr, 1'b0);

        // Overflow / underflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ret_exp[i] = pc_q + 8'd1;
            do_call(8'h30 + 8'(i));
        end
        chk("full_after_4", stack_full, 1'b1);
        chk("err_after_4", stack_err, 1'b0);
        do_call(8'h70);
        chk("call5_pc", pc_q, 8'h70);
        chk("call5_err", stack_err, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            do_ret();
            chk("ovf_ret_pc", pc_q, ret_exp[i]);
        end
        ret_exp[4] = pc_q + 8'd1;
        ret_req = 1'b1; step(); clr_in();
        chk("underflow_pc", pc_q, ret_exp[4]);
        chk("underflow_err", stack_err, 1'b1);

        // Reset during FLUSH with an interrupt pending
        do_reset();
        for (int i = 0; i < 4; i++) do_call(8'hA0 + 8'(i));
        irq = 1'b1; step(); irq = 1'b0;
        br_req = 1'b1; br_target = 8'h60; step(); clr_in();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_flush_pc", pc_q, RV);
        chk("rst_flush_isr", in_isr, 1'b0);
        ack_seen = 1'b0;
        repeat (6) begin
            step();
            ack_seen |= s_ack;
        end
        chk("rst_no_ack", ack_seen, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            stall     = ($urandom_range(0, 5) == 0);
            irq       = ($urandom_range(0, 11) == 0);
            ret_req   = ($urandom_range(0, 6) == 0);
            call_req  = ($urandom_range(0, 5) == 0);
            br_req    = ($urandom_range(0, 5) == 0);
            br_target = 8'($urandom);
            step();
        end
        clr_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
